chu_mcs_fpro_bridge: RTL and testbench

Registered bridge between the MicroBlaze MCS I/O bus and the FPro bus that feeds the MMIO subsystem (`mmio_cs`, `mmio_wr`, `mmio_rd`, `mmio_addr`, `mmio_wr_data`, `mmio_rd_data`) and the video subsystem. It runs one transaction at a time through a small FSM. It decodes the bridge window and splits MMIO from video space. It drives single-cycle FPro strobes, captures read data after a programmable wait, and returns a one-cycle `io_ready` to the processor.

---
 rtl/chu_mcs_fpro_bridge.sv | 168 ++++++++++++++++
 tb/tb_chu_mcs_fpro_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chu_mcs_fpro_bridge.sv
// chu_mcs_fpro_bridge: registered bridge from the MicroBlaze MCS I/O bus to the
// FPro bus that feeds the MMIO and video subsystems. It runs one transaction at
// a time.
//   clk, reset (async, active-low)
//   io_*        : MCS I/O bus (strobes, byte enables, address, data, ready)
//   fp_*        : FPro bus (mmio/video selects, wr/rd strobes, word address, data)
//   bus_err     : one-cycle pulse on out-of-window, malformed or partial-byte access
module chu_mcs_fpro_bridge #(
   parameter logic [31:0] BRG_BASE = 32'hc000_0000,
   parameter int unsigned RD_WAIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_addr_strobe,
   input  logic        io_read_strobe,
   input  logic        io_write_strobe,
   input  logic [3:0]  io_byte_enable,
   input  logic [31:0] io_address,
   input  logic [31:0] io_write_data,
   output logic [31:0] io_read_data,
   output logic        io_ready,
   output logic        fp_mmio_cs,
   output logic        fp_video_cs,
   output logic        fp_wr,
   output logic        fp_rd,
   output logic [20:0] fp_addr,
   output logic [31:0] fp_wr_data,
   input  logic [31:0] fp_rd_data,
   output logic        bus_err
);

   localparam int unsigned DW  = 32;
   localparam int unsigned FAW = 21;
   localparam int unsigned CW  = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   state_t         state_q, state_d;
   logic           wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [FAW-1:0] fp_addr_q, fp_addr_d;
   logic [DW-1:0]  fp_wr_data_q, fp_wr_data_d;
   logic [DW-1:0]  io_read_data_q, io_read_data_d;
   logic           io_ready_q, io_ready_d;
   logic           fp_mmio_cs_q, fp_mmio_cs_d;
   logic           fp_video_cs_q, fp_video_cs_d;
   logic           fp_wr_q, fp_wr_d;
   logic           fp_rd_q, fp_rd_d;
   logic           bus_err_q, bus_err_d;

   logic req_rd_c, req_wr_c, in_win_c;
   logic unused_addr_lsb_c;

   // Byte address bits [1:0] have no meaning on a word-addressed FPro bus.
   assign unused_addr_lsb_c = ^io_address[1:0];

   // Request decode: a valid request carries exactly one direction strobe.
   assign req_rd_c = io_addr_strobe &  io_read_strobe & ~io_write_strobe;
   assign req_wr_c = io_addr_strobe & ~io_read_strobe &  io_write_strobe;
   assign in_win_c = (io_address[31:24] == BRG_BASE[31:24]);

   // Next-state and registered-output logic. FPro strobes are computed one
   // state ahead so they are flop outputs while the FSM sits in ISSUE.
   always_comb begin
      state_d        = state_q;
      wr_d           = wr_q;
      cnt_d          = cnt_q;
      fp_addr_d      = fp_addr_q;
      fp_wr_data_d   = fp_wr_data_q;
      io_read_data_d = '0;
      io_ready_d     = 1'b0;
      fp_mmio_cs_d   = 1'b0;
      fp_video_cs_d  = 1'b0;
      fp_wr_d        = 1'b0;
      fp_rd_d        = 1'b0;
      bus_err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_rd_c || req_wr_c) begin
               wr_d         = req_wr_c;
               fp_addr_d    = io_address[22:2];
               fp_wr_data_d = io_write_data;
               if (in_win_c) begin
                  state_d       = ST_ISSUE;
                  fp_video_cs_d = io_address[23];
                  fp_mmio_cs_d  = ~io_address[23];
                  fp_wr_d       = req_wr_c;
                  fp_rd_d       = req_rd_c;
                  // Partial writes still go out as full words but are flagged.
                  bus_err_d     = req_wr_c && (io_byte_enable != 4'b1111);
               end else begin
                  state_d    = ST_DONE;
                  io_ready_d = 1'b1;
                  bus_err_d  = 1'b1;
               end
            end else if (io_addr_strobe) begin
               bus_err_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (wr_q) begin
               state_d    = ST_DONE;
               io_ready_d = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CW'(RD_WAIT);
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d        = ST_DONE;
               io_ready_d     = 1'b1;
               io_read_data_d = fp_rd_data;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         wr_q           <= 1'b0;
         cnt_q          <= '0;
         fp_addr_q      <= '0;
         fp_wr_data_q   <= '0;
         io_read_data_q <= '0;
         io_ready_q     <= 1'b0;
         fp_mmio_cs_q   <= 1'b0;
         fp_video_cs_q  <= 1'b0;
         fp_wr_q        <= 1'b0;
         fp_rd_q        <= 1'b0;
         bus_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_q           <= wr_d;
         cnt_q          <= cnt_d;
         fp_addr_q      <= fp_addr_d;
         fp_wr_data_q   <= fp_wr_data_d;
         io_read_data_q <= io_read_data_d;
         io_ready_q     <= io_ready_d;
         fp_mmio_cs_q   <= fp_mmio_cs_d;
         fp_video_cs_q  <= fp_video_cs_d;
         fp_wr_q        <= fp_wr_d;
         fp_rd_q        <= fp_rd_d;
         bus_err_q      <= bus_err_d;
      end
   end

   assign io_read_data = io_read_data_q;
   assign io_ready     = io_ready_q;
   assign fp_mmio_cs   = fp_mmio_cs_q;
   assign fp_video_cs  = fp_video_cs_q;
   assign fp_wr        = fp_wr_q;
   assign fp_rd        = fp_rd_q;
   assign fp_addr      = fp_addr_q;
   assign fp_wr_data   = fp_wr_data_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_chu_mcs_fpro_bridge.sv
// Testbench for chu_mcs_fpro_bridge: two instances (RD_WAIT=1 and RD_WAIT=4)
// share the bus inputs but have private address strobes and resets.
module tb_chu_mcs_fpro_bridge;

   logic        clk = 1'b0;
   logic        rst1, rst4, as1, as4, rs, ws;
   logic [3:0]  be;
   logic [31:0] addr, wdata, rdin;

   logic [31:0] rdat1, rdat4, fpwd1, fpwd4;
   logic        rdy1, rdy4, mcs1, mcs4, vcs1, vcs4, fwr1, fwr4, frd1, frd4, err1, err4;
   logic [20:0] fpa1, fpa4;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   chu_mcs_fpro_bridge #(.BRG_BASE(32'hc000_0000), .RD_WAIT(1)) dut1 (
      .clk(clk), .reset(rst1), .io_addr_strobe(as1), .io_read_strobe(rs),
      .io_write_strobe(ws), .io_byte_enable(be), .io_address(addr),
      .io_write_data(wdata), .io_read_data(rdat1), .io_ready(rdy1),
      .fp_mmio_cs(mcs1), .fp_video_cs(vcs1), .fp_wr(fwr1), .fp_rd(frd1),
      .fp_addr(fpa1), .fp_wr_data(fpwd1), .fp_rd_data(rdin), .bus_err(err1));

   chu_mcs_fpro_bridge #(.BRG_BASE(32'hc000_0000), .RD_WAIT(4)) dut4 (
      .clk(clk), .reset(rst4), .io_addr_strobe(as4), .io_read_strobe(rs),
      .io_write_strobe(ws), .io_byte_enable(be), .io_address(addr),
      .io_write_data(wdata), .io_read_data(rdat4), .io_ready(rdy4),
      .fp_mmio_cs(mcs4), .fp_video_cs(vcs4), .fp_wr(fwr4), .fp_rd(frd4),
      .fp_addr(fpa4), .fp_wr_data(fpwd4), .fp_rd_data(rdin), .bus_err(err4));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard monitors: pop an expected response whenever io_ready is seen.
   always @(negedge clk) begin
      exp_t e;
      if (rdy1) begin
         chk("ready1_expected", 64'(q1.size() > 0), 64'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("ready1_cycle", 64'(cyc), 64'(e.due));
            chk("rdata1", 64'(rdat1), 64'(e.data));
         end
      end else begin
         chk("rdata1_idle_zero", 64'(rdat1), 64'd0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rdy4) begin
         chk("ready4_expected", 64'(q4.size() > 0), 64'd1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("ready4_cycle", 64'(cyc), 64'(e.due));
            chk("rdata4", 64'(rdat4), 64'(e.data));
         end
      end else begin
         chk("rdata4_idle_zero", 64'(rdat4), 64'd0);
      end
   end

   // Issue one MCS request; returns at the falling edge inside T0+1.
   // lat is the spec latency from T0 to io_ready (0 = no response expected).
   task automatic start(input bit sel4, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input int lat, input logic [31:0] exp_data);
      exp_t e;
      int   tc;
      @(negedge clk);
      addr  = a;
      wdata = d;
      be    = b;
      rs    = r;
      ws    = w;
      if (sel4) as4 = 1'b1;
      else      as1 = 1'b1;
      tc = cyc + 1;
      if (lat > 0) begin
         e.data = exp_data;
         e.due  = tc + lat - 1;
         if (sel4) q4.push_back(e);
         else      q1.push_back(e);
      end
      @(negedge clk);
      as1 = 1'b0;
      as4 = 1'b0;
      rs  = 1'b0;
      ws  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst1 = 1'b0; rst4 = 1'b0; as1 = 1'b0; as4 = 1'b0; rs = 1'b0; ws = 1'b0;
      be = 4'h0; addr = '0; wdata = '0; rdin = '0;
      idle(3);
      chk("reset_ctrl1", 64'({rdy1, mcs1, vcs1, fwr1, frd1, err1}), 64'd0);
      chk("reset_addr1", 64'(fpa1), 64'd0);
      chk("reset_wdata1", 64'(fpwd1), 64'd0);
      rst1 = 1'b1;
      rst4 = 1'b1;
      idle(2);

      // Full-word MMIO write
      start(1'b0, 1'b0, 1'b1, 32'hc000_0208, 32'h0000_00a5, 4'b1111, 2, 32'h0);
      chk("wr_mmio_cs", 64'({mcs1, vcs1}), 64'b10);
      chk("wr_strobes", 64'({fwr1, frd1}), 64'b10);
      chk("wr_addr", 64'(fpa1), 64'h82);
      chk("wr_data", 64'(fpwd1), 64'ha5);
      chk("wr_no_err", 64'(err1), 64'd0);
      idle(1);
      chk("wr_pulse_single", 64'({mcs1, fwr1, err1}), 64'd0);
      chk("wr_addr_held", 64'(fpa1), 64'h82);
      idle(3);

      // MMIO read, RD_WAIT=1
      rdin = 32'h1234_5678;
      start(1'b0, 1'b1, 1'b0, 32'hc000_0200, 32'h0, 4'b1111, 3, 32'h1234_5678);
      chk("rd_strobes", 64'({mcs1, vcs1, fwr1, frd1}), 64'b1001);
      chk("rd_addr", 64'(fpa1), 64'h80);
      idle(1);
      chk("rd_pulse_single", 64'({mcs1, frd1}), 64'd0);
      idle(4);

      // Video read
      rdin = 32'hcafe_0001;
      start(1'b0, 1'b1, 1'b0, 32'hc080_0010, 32'h0, 4'b0000, 3, 32'hcafe_0001);
      chk("vid_cs", 64'({mcs1, vcs1, frd1}), 64'b011);
      chk("vid_addr", 64'(fpa1), 64'h4);
      idle(4);

      // Out-of-window read
      rdin = 32'hffff_ffff;
      start(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b1111, 1, 32'h0);
      chk("oow_no_strobes", 64'({mcs1, vcs1, fwr1, frd1}), 64'd0);
      chk("oow_err", 64'(err1), 64'd1);
      idle(1);
      chk("oow_err_single", 64'(err1), 64'd0);
      idle(3);

      // Partial-byte write
      start(1'b0, 1'b0, 1'b1, 32'hc000_0004, 32'h1122_3344, 4'b0011, 2, 32'h0);
      chk("pw_strobes", 64'({mcs1, fwr1}), 64'b11);
      chk("pw_data", 64'(fpwd1), 64'h1122_3344);
      chk("pw_err", 64'(err1), 64'd1);
      idle(1);
      chk("pw_err_single", 64'(err1), 64'd0);
      idle(3);

      // Both direction strobes: ignored, error pulse only
      start(1'b0, 1'b1, 1'b1, 32'hc000_0000, 32'h0, 4'b1111, 0, 32'h0);
      chk("both_no_strobes", 64'({mcs1, vcs1, fwr1, frd1}), 64'd0);
      chk("both_err", 64'(err1), 64'd1);
      idle(4);

      // RD_WAIT=4 read
      rdin = 32'hdead_beef;
      start(1'b1, 1'b1, 1'b0, 32'hc000_0300, 32'h0, 4'b1111, 6, 32'hdead_beef);
      chk("rd4_strobes", 64'({mcs4, frd4}), 64'b11);
      chk("rd4_addr", 64'(fpa4), 64'hc0);
      idle(8);

      // RD_WAIT=4 read aborted by reset in T0+3
      start(1'b1, 1'b1, 1'b0, 32'hc000_0300, 32'h0, 4'b1111, 0, 32'h0);
      idle(2);
      chk("abort_addr_before", 64'(fpa4), 64'hc0);
      rst4 = 1'b0;
      #1;
      chk("abort_ctrl", 64'({rdy4, mcs4, vcs4, fwr4, frd4, err4}), 64'd0);
      chk("abort_addr", 64'(fpa4), 64'd0);
      chk("abort_rdata", 64'(rdat4), 64'd0);
      idle(2);
      rst4 = 1'b1;
      idle(8);

      // Normal write after abort
      start(1'b1, 1'b0, 1'b1, 32'hc000_0010, 32'h0000_0055, 4'b1111, 2, 32'h0);
      chk("post_abort_wr", 64'({mcs4, fwr4}), 64'b11);
      chk("post_abort_addr", 64'(fpa4), 64'h4);
      idle(5);

      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q4_drained", 64'(q4.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
